// File: rtl/xilinx_gmem_rd_arbiter_if.sv
// xilinx_gmem_rd_arbiter_if: requester-side channels plus the m_axi_gmem AR/R pair
interface xilinx_gmem_rd_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 42,
  parameter int DATA_W = 512,
  parameter int ID_W   = 4
);
  logic [NUM_CH-1:0]        ch_arvalid;
  logic [NUM_CH-1:0]        ch_arready;
  logic [NUM_CH*ADDR_W-1:0] ch_araddr;
  logic [NUM_CH*8-1:0]      ch_arlen;
  logic [NUM_CH-1:0]        ch_rvalid;
  logic [NUM_CH-1:0]        ch_rready;
  logic [DATA_W-1:0]        ch_rdata;
  logic                     ch_rlast;
  logic [NUM_CH-1:0]        ch_err;
  logic                     bad_id;
  logic                     m_axi_gmem_ARVALID;
  logic                     m_axi_gmem_ARREADY;
  logic [ADDR_W-1:0]        m_axi_gmem_ARADDR;
  logic [ID_W-1:0]          m_axi_gmem_ARID;
  logic [7:0]               m_axi_gmem_ARLEN;
  logic [2:0]               m_axi_gmem_ARSIZE;
  logic [1:0]               m_axi_gmem_ARBURST;
  logic                     m_axi_gmem_ARLOCK;
  logic [3:0]               m_axi_gmem_ARCACHE;
  logic [2:0]               m_axi_gmem_ARPROT;
  logic [3:0]               m_axi_gmem_ARQOS;
  logic [3:0]               m_axi_gmem_ARREGION;
  logic                     m_axi_gmem_RVALID;
  logic                     m_axi_gmem_RREADY;
  logic [DATA_W-1:0]        m_axi_gmem_RDATA;
  logic                     m_axi_gmem_RLAST;
  logic [ID_W-1:0]          m_axi_gmem_RID;
  logic [1:0]               m_axi_gmem_RRESP;
  modport master (
    input  ch_arvalid, ch_araddr, ch_arlen, ch_rready,
    input  m_axi_gmem_ARREADY, m_axi_gmem_RVALID, m_axi_gmem_RDATA, m_axi_gmem_RLAST,
    input  m_axi_gmem_RID, m_axi_gmem_RRESP,
    output ch_arready, ch_rvalid, ch_rdata, ch_rlast, ch_err, bad_id,
    output m_axi_gmem_ARVALID, m_axi_gmem_ARADDR, m_axi_gmem_ARID, m_axi_gmem_ARLEN,
    output m_axi_gmem_ARSIZE, m_axi_gmem_ARBURST, m_axi_gmem_ARLOCK, m_axi_gmem_ARCACHE,
    output m_axi_gmem_ARPROT, m_axi_gmem_ARQOS, m_axi_gmem_ARREGION, m_axi_gmem_RREADY
  );
  modport slave (
    output ch_arvalid, ch_araddr, ch_arlen, ch_rready,
    output m_axi_gmem_ARREADY, m_axi_gmem_RVALID, m_axi_gmem_RDATA, m_axi_gmem_RLAST,
    output m_axi_gmem_RID, m_axi_gmem_RRESP,
    input  ch_arready, ch_rvalid, ch_rdata, ch_rlast, ch_err, bad_id,
    input  m_axi_gmem_ARVALID, m_axi_gmem_ARADDR, m_axi_gmem_ARID, m_axi_gmem_ARLEN,
    input  m_axi_gmem_ARSIZE, m_axi_gmem_ARBURST, m_axi_gmem_ARLOCK, m_axi_gmem_ARCACHE,
    input  m_axi_gmem_ARPROT, m_axi_gmem_ARQOS, m_axi_gmem_ARREGION, m_axi_gmem_RREADY
  );
endinterface

// File: rtl/xilinx_gmem_rd_arbiter.sv
// xilinx_gmem_rd_arbiter: round-robin NUM_CH-to-1 AXI4 read arbiter, one AR register stage, RID routing
module xilinx_gmem_rd_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 42,
  parameter int DATA_W  = 512,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 8
)(
  input logic ap_clk,
  input logic ap_rst,
  xilinx_gmem_rd_arbiter_if.master bus
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [PW-1:0]     r_ptr, w_grant, w_scan;
  logic              w_found, w_load, w_rid_ok, w_rhs;
  logic [NUM_CH-1:0] w_elig, w_inc, w_dec, w_uflow, w_rsel;
  logic              r_arvalid, r_bad;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [ID_W-1:0]   r_arid;
  logic [NUM_CH-1:0] r_err;
  assign w_load   = !r_arvalid || bus.m_axi_gmem_ARREADY;
  assign w_rid_ok = 32'(bus.m_axi_gmem_RID) < NUM_CH;
  assign w_rhs    = bus.m_axi_gmem_RVALID && bus.m_axi_gmem_RREADY;
  assign w_inc    = bus.ch_arvalid & bus.ch_arready;
  // scan starts one past the last winner so every requester gets a turn
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_scan  = r_ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      w_scan = (w_scan == PW'(NUM_CH - 1)) ? '0 : w_scan + 1'b1;
      if (!w_found && w_elig[w_scan]) begin
        w_found = 1'b1;
        w_grant = w_scan;
      end
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [7:0] r_cnt;
    assign w_rsel[i]  = bus.m_axi_gmem_RID == ID_W'(i);
    assign w_elig[i]  = bus.ch_arvalid[i] && r_cnt < 8'(MAX_OUT);
    assign w_dec[i]   = w_rhs && bus.m_axi_gmem_RLAST && w_rsel[i];
    assign w_uflow[i] = w_dec[i] && !w_inc[i] && r_cnt == 8'd0;
    always_ff @(posedge ap_clk or posedge ap_rst)
      if (ap_rst) r_cnt <= '0;
      else if (w_inc[i] && !w_dec[i]) r_cnt <= r_cnt + 8'd1;
      else if (w_dec[i] && !w_inc[i] && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
  end
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arid    <= '0;
      r_ptr     <= PW'(NUM_CH - 1);
    end else if (w_load) begin
      r_arvalid <= w_found;
      if (w_found) begin
        r_araddr <= bus.ch_araddr[w_grant*ADDR_W +: ADDR_W];
        r_arlen  <= bus.ch_arlen[w_grant*8 +: 8];
        r_arid   <= ID_W'(w_grant);
        r_ptr    <= w_grant;
      end
    end
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      r_err <= '0;
      r_bad <= 1'b0;
    end else begin
      r_err <= r_err | ((w_rhs && bus.m_axi_gmem_RRESP != 2'b00) ? bus.ch_rvalid : '0);
      r_bad <= r_bad || (w_rhs && !w_rid_ok) || |w_uflow;
    end
  assign bus.ch_arready          = (w_load && w_found) ? NUM_CH'(1) << w_grant : '0;
  assign bus.ch_rvalid           = bus.m_axi_gmem_RVALID ? w_rsel : '0;
  assign bus.ch_rdata            = bus.m_axi_gmem_RDATA;
  assign bus.ch_rlast            = bus.m_axi_gmem_RLAST;
  assign bus.ch_err              = r_err;
  assign bus.bad_id              = r_bad;
  assign bus.m_axi_gmem_RREADY   = w_rid_ok ? |(bus.ch_rready & w_rsel) : 1'b1;
  assign bus.m_axi_gmem_ARVALID  = r_arvalid;
  assign bus.m_axi_gmem_ARADDR   = r_araddr;
  assign bus.m_axi_gmem_ARID     = r_arid;
  assign bus.m_axi_gmem_ARLEN    = r_arlen;
  assign bus.m_axi_gmem_ARSIZE   = 3'($clog2(DATA_W / 8));
  assign bus.m_axi_gmem_ARBURST  = 2'b01;
  assign bus.m_axi_gmem_ARLOCK   = 1'b0;
  assign bus.m_axi_gmem_ARCACHE  = 4'b0011;
  assign bus.m_axi_gmem_ARPROT   = 3'b000;
  assign bus.m_axi_gmem_ARQOS    = 4'b0000;
  assign bus.m_axi_gmem_ARREGION = 4'b0000;
endmodule

// File: tb/tb_xilinx_gmem_rd_arbiter.sv
// tb_xilinx_gmem_rd_arbiter: directed scenarios plus random traffic checked against a behavioural model
module tb_xilinx_gmem_rd_arbiter;
  localparam int NC = 4, AW = 42, DW = 512, IW = 4, MO = 2;
  logic ap_clk = 1'b0, ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;
  xilinx_gmem_rd_arbiter_if #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus();
  xilinx_gmem_rd_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUT(MO)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus.master));
  int n_vec = 0, n_err = 0;
  int m_ptr, m_id;
  int m_cnt [NC];
  bit m_arv, m_bad, hs_r, r_from_q;
  logic [AW-1:0] m_addr;
  logic [7:0] m_len;
  logic [NC-1:0] m_err, hs_ch;
  typedef struct {int id; int beats;} burst_t;
  burst_t bq [$];
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction
  function automatic void m_reset();
    m_ptr = NC - 1;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_arv = 1'b0;
    m_err = '0;
    m_bad = 1'b0;
    bq.delete();
  endfunction
  // first requester after the last winner that is requesting and under the outstanding limit
  function automatic int pick();
    for (int k = 1; k <= NC; k++) begin
      int c = (m_ptr + k) % NC;
      if (|(bus.ch_arvalid & (NC'(1) << c)) && m_cnt[c] < MO) return c;
    end
    return -1;
  endfunction
  task automatic cycle();
    int g, rid;
    bit load, ridok;
    logic [NC-1:0] e_ar, e_rv;
    logic e_rr;
    @(negedge ap_clk);
    if (ap_rst) m_reset();
    load  = !m_arv || bus.m_axi_gmem_ARREADY;
    g     = pick();
    e_ar  = (load && g >= 0) ? NC'(1) << g : '0;
    rid   = int'(bus.m_axi_gmem_RID);
    ridok = rid < NC;
    e_rr  = ridok ? |(bus.ch_rready & (NC'(1) << rid)) : 1'b1;
    e_rv  = (bus.m_axi_gmem_RVALID && ridok) ? NC'(1) << rid : '0;
    chk("ch_arready", DW'(bus.ch_arready), DW'(e_ar));
    chk("arvalid", DW'(bus.m_axi_gmem_ARVALID), DW'(m_arv));
    if (m_arv) begin
      chk("araddr", DW'(bus.m_axi_gmem_ARADDR), DW'(m_addr));
      chk("arid", DW'(bus.m_axi_gmem_ARID), DW'(m_id));
      chk("arlen", DW'(bus.m_axi_gmem_ARLEN), DW'(m_len));
    end
    chk("ar_tieoff", DW'({bus.m_axi_gmem_ARSIZE, bus.m_axi_gmem_ARBURST, bus.m_axi_gmem_ARLOCK,
        bus.m_axi_gmem_ARCACHE, bus.m_axi_gmem_ARPROT, bus.m_axi_gmem_ARQOS, bus.m_axi_gmem_ARREGION}),
        DW'({3'd6, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0}));
    chk("ch_rvalid", DW'(bus.ch_rvalid), DW'(e_rv));
    chk("rready", DW'(bus.m_axi_gmem_RREADY), DW'(e_rr));
    chk("ch_rdata", bus.ch_rdata, bus.m_axi_gmem_RDATA);
    chk("ch_rlast", DW'(bus.ch_rlast), DW'(bus.m_axi_gmem_RLAST));
    chk("ch_err", DW'(bus.ch_err), DW'(m_err));
    chk("bad_id", DW'(bus.bad_id), DW'(m_bad));
    hs_ch = '0;
    hs_r  = 1'b0;
    if (!ap_rst) begin
      if (m_arv && bus.m_axi_gmem_ARREADY) bq.push_back('{id: m_id, beats: int'(m_len) + 1});
      hs_ch = e_ar;
      hs_r  = bus.m_axi_gmem_RVALID && e_rr;
      if (load) begin
        m_arv = g >= 0;
        if (g >= 0) begin
          m_addr = bus.ch_araddr[g*AW +: AW];
          m_len  = bus.ch_arlen[g*8 +: 8];
          m_id   = g;
          m_ptr  = g;
        end
      end
      for (int i = 0; i < NC; i++) begin
        bit inc = load && g == i;
        bit dec = hs_r && bus.m_axi_gmem_RLAST && rid == i;
        if (inc && !dec) m_cnt[i]++;
        else if (dec && !inc) begin
          if (m_cnt[i] == 0) m_bad = 1'b1;
          else m_cnt[i]--;
        end
      end
      if (hs_r && !ridok) m_bad = 1'b1;
      if (hs_r && ridok && bus.m_axi_gmem_RRESP != 2'b00) m_err = m_err | (NC'(1) << rid);
    end
  endtask
  task automatic nxt();
    @(posedge ap_clk);
    #1;
  endtask
  task automatic idle();
    bus.ch_arvalid = '0;
    bus.ch_araddr = '0;
    bus.ch_arlen = '0;
    bus.ch_rready = '1;
    bus.m_axi_gmem_ARREADY = 1'b1;
    bus.m_axi_gmem_RVALID = 1'b0;
    bus.m_axi_gmem_RDATA = '0;
    bus.m_axi_gmem_RLAST = 1'b0;
    bus.m_axi_gmem_RID = '0;
    bus.m_axi_gmem_RRESP = 2'b00;
  endtask
  task automatic do_reset();
    idle();
    ap_rst = 1'b1;
    cycle();
    nxt();
    ap_rst = 1'b0;
  endtask
  initial begin
    hs_ch = '0;
    hs_r = 1'b0;
    r_from_q = 1'b0;
    m_reset();
    do_reset();
    chk("reset_arvalid", DW'(bus.m_axi_gmem_ARVALID), DW'(1'b0));
    chk("reset_flags", DW'({bus.ch_err, bus.bad_id}), DW'(5'b0));
    // single request from ch2
    bus.ch_arvalid = 4'b0100;
    bus.ch_araddr[2*AW +: AW] = 42'h1000;
    bus.ch_arlen[16 +: 8] = 8'd3;
    cycle();
    chk("t1_grant", DW'(bus.ch_arready), DW'(4'b0100));
    nxt();
    bus.ch_arvalid = '0;
    cycle();
    chk("t1_ar", DW'({bus.m_axi_gmem_ARVALID, bus.m_axi_gmem_ARID, bus.m_axi_gmem_ARLEN, bus.m_axi_gmem_ARADDR}),
        DW'({1'b1, 4'd2, 8'd3, 42'h1000}));
    nxt();
    for (int b = 0; b < 4; b++) begin
      bus.m_axi_gmem_RVALID = 1'b1;
      bus.m_axi_gmem_RID = 4'd2;
      bus.m_axi_gmem_RLAST = b == 3;
      bus.m_axi_gmem_RDATA = rnd_data();
      cycle();
      chk("t1_rvalid", DW'(bus.ch_rvalid), DW'(4'b0100));
      nxt();
    end
    idle();
    chk("t1_cnt_model", DW'(m_cnt[2]), DW'(0));
    // fairness
    do_reset();
    bus.ch_arvalid = 4'b1111;
    for (int c = 0; c < NC; c++) bus.ch_araddr[c*AW +: AW] = AW'(c * 256);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("fair_grant", DW'(bus.ch_arready), DW'(NC'(1) << (k % 4)));
      if (k > 0) chk("fair_arid", DW'({bus.m_axi_gmem_ARVALID, bus.m_axi_gmem_ARID}), DW'({1'b1, 4'((k - 1) % 4)}));
      nxt();
    end
    cycle();
    chk("fair_limit", DW'(bus.ch_arready), DW'(4'b0000));
    nxt();
    // AR backpressure
    do_reset();
    bus.ch_arvalid = 4'b0001;
    bus.ch_araddr[0 +: AW] = 42'h3_0000_0040;
    bus.m_axi_gmem_ARREADY = 1'b0;
    cycle();
    chk("bp_grant", DW'(bus.ch_arready), DW'(4'b0001));
    nxt();
    bus.ch_arvalid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_hold", DW'({bus.ch_arready, bus.m_axi_gmem_ARID, bus.m_axi_gmem_ARADDR}), DW'({4'b0, 4'd0, 42'h3_0000_0040}));
      nxt();
    end
    bus.m_axi_gmem_ARREADY = 1'b1;
    cycle();
    chk("bp_release", DW'(bus.ch_arready), DW'(4'b0010));
    nxt();
    // outstanding limit
    do_reset();
    bus.ch_arvalid = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("lim_ch1", DW'(bus.ch_arready), DW'(4'b0010));
      nxt();
    end
    bus.ch_arvalid = 4'b1010;
    cycle();
    chk("lim_ch3", DW'(bus.ch_arready), DW'(4'b1000));
    nxt();
    bus.ch_arvalid = 4'b0010;
    bus.m_axi_gmem_RVALID = 1'b1;
    bus.m_axi_gmem_RID = 4'd1;
    bus.m_axi_gmem_RLAST = 1'b1;
    cycle();
    chk("lim_blocked", DW'(bus.ch_arready), DW'(4'b0000));
    nxt();
    bus.m_axi_gmem_RVALID = 1'b0;
    cycle();
    chk("lim_unblock", DW'(bus.ch_arready), DW'(4'b0010));
    nxt();
    // bad ID, RRESP error, decrement at zero
    do_reset();
    bus.ch_rready = '0;
    bus.m_axi_gmem_RVALID = 1'b1;
    bus.m_axi_gmem_RID = 4'd7;
    cycle();
    chk("bad_rready", DW'({bus.m_axi_gmem_RREADY, bus.ch_rvalid}), DW'(5'b10000));
    nxt();
    bus.m_axi_gmem_RID = 4'd0;
    bus.m_axi_gmem_RRESP = 2'd2;
    bus.ch_rready = 4'b0001;
    cycle();
    chk("bad_sticky", DW'(bus.bad_id), DW'(1'b1));
    nxt();
    idle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("err_sticky", DW'(bus.ch_err), DW'(4'b0001));
      nxt();
    end
    do_reset();
    bus.m_axi_gmem_RVALID = 1'b1;
    bus.m_axi_gmem_RID = 4'd1;
    bus.m_axi_gmem_RLAST = 1'b1;
    cycle();
    nxt();
    idle();
    cycle();
    chk("uflow_bad", DW'(bus.bad_id), DW'(1'b1));
    nxt();
    // async reset mid-burst
    do_reset();
    bus.ch_arvalid = 4'b0100;
    bus.m_axi_gmem_ARREADY = 1'b0;
    cycle();
    nxt();
    bus.ch_arvalid = '0;
    bus.m_axi_gmem_RVALID = 1'b1;
    bus.m_axi_gmem_RID = 4'd3;
    bus.m_axi_gmem_RRESP = 2'd1;
    cycle();
    nxt();
    bus.m_axi_gmem_RVALID = 1'b0;
    bus.m_axi_gmem_RRESP = 2'd0;
    cycle();
    chk("pre_rst", DW'({bus.m_axi_gmem_ARVALID, bus.ch_err}), DW'(5'b11000));
    #2 ap_rst = 1'b1;
    #1;
    chk("async_rst", DW'({bus.m_axi_gmem_ARVALID, bus.ch_err, bus.bad_id}), DW'(6'b0));
    cycle();
    nxt();
    ap_rst = 1'b0;
    bus.ch_arvalid = 4'b1111;
    bus.m_axi_gmem_ARREADY = 1'b1;
    cycle();
    chk("post_rst", DW'(bus.ch_arready), DW'(4'b0001));
    nxt();
    // random traffic
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      logic [NC-1:0] av = bus.ch_arvalid;
      for (int c = 0; c < NC; c++) begin
        logic [NC-1:0] m = NC'(1) << c;
        if (!(|(av & m)) || |(hs_ch & m)) begin
          if ($urandom % 3 == 0) begin
            av = av | m;
            bus.ch_araddr[c*AW +: AW] = AW'({$urandom, $urandom});
            bus.ch_arlen[c*8 +: 8] = 8'($urandom % 4);
          end else av = av & ~m;
        end
      end
      bus.ch_arvalid = av;
      bus.m_axi_gmem_ARREADY = $urandom % 4 != 0;
      bus.ch_rready = NC'($urandom);
      if (!bus.m_axi_gmem_RVALID || hs_r) begin
        if (hs_r && r_from_q) begin
          bq[0].beats--;
          if (bq[0].beats == 0) void'(bq.pop_front());
        end
        r_from_q = 1'b0;
        bus.m_axi_gmem_RVALID = 1'b0;
        if (bq.size() > 0 && $urandom % 4 != 0) begin
          bus.m_axi_gmem_RVALID = 1'b1;
          bus.m_axi_gmem_RID = IW'(bq[0].id);
          bus.m_axi_gmem_RLAST = bq[0].beats == 1;
          bus.m_axi_gmem_RRESP = ($urandom % 8 == 0) ? 2'($urandom) : 2'b00;
          bus.m_axi_gmem_RDATA = rnd_data();
          r_from_q = 1'b1;
        end else if ($urandom % 64 == 0) begin
          bus.m_axi_gmem_RVALID = 1'b1;
          bus.m_axi_gmem_RID = IW'(4 + $urandom % 12);
          bus.m_axi_gmem_RLAST = 1'($urandom);
          bus.m_axi_gmem_RDATA = rnd_data();
        end
      end
      cycle();
      nxt();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
